fifo_traffic_gen: RTL

FIFO_TRAFFIC_GEN -- requirements
Module: fifo_traffic_gen

---
 rtl/fifo_traffic_gen.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/fifo_traffic_gen.sv
// Burst traffic generator driving a FIFO write/read port with an incrementing data pattern.
// Define FIFO_TG_CHECK_EN to enable read-data checking into ERR_CNT; otherwise ERR_CNT is tied to 0.
module fifo_traffic_gen #(
  parameter int  DATA_W    = 8,
  parameter int  BURST_MAX = 16,
  parameter int  GAP       = 1,
  localparam int LEN_W     = $clog2(BURST_MAX + 1)
) (
  input  logic              SYSCLK,
  input  logic              RST,
  input  logic              START,
  input  logic [1:0]        MODE,
  input  logic [LEN_W-1:0]  BURST_LEN,
  input  logic [DATA_W-1:0] SEED,
  input  logic              FULL,
  input  logic              EMPTY,
  input  logic [DATA_W-1:0] FIFO_OUT,
  output logic              WR_EN,
  output logic              RD_EN,
  output logic [DATA_W-1:0] FIFO_IN,
  output logic              BUSY,
  output logic              DONE,
  output logic [LEN_W-1:0]  WR_CNT,
  output logic [LEN_W-1:0]  RD_CNT,
  output logic [7:0]        ERR_CNT
);

  localparam int               GAP_W    = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP > 0) ? GAP - 1 : 0);
  localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(BURST_MAX);
  localparam logic [1:0]       MODE_RD    = 2'b01;
  localparam logic [1:0]       MODE_WR_RD = 2'b10;
  localparam logic [1:0]       MODE_NOP   = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR_BEAT = 3'd1,
    S_WR_GAP  = 3'd2,
    S_RD_BEAT = 3'd3,
    S_RD_GAP  = 3'd4,
    S_FLUSH   = 3'd5,
    S_DONE    = 3'd6
  } state_t;

  state_t              state_r;
  state_t              state_nxt_s;
  logic [1:0]          mode_r;
  logic [LEN_W-1:0]    len_r;
  logic [DATA_W-1:0]   seed_r;
  logic [LEN_W-1:0]    wr_cnt_r;
  logic [LEN_W-1:0]    rd_cnt_r;
  logic [GAP_W-1:0]    gap_cnt_r;
  logic                busy_r;
  logic                done_r;
  logic [LEN_W-1:0]    len_clamp_s;
  logic                start_acc_s;
  logic                wr_en_s;
  logic                rd_en_s;
  logic                wr_last_s;
  logic                rd_last_s;

  assign len_clamp_s = (BURST_LEN > LEN_MAX) ? LEN_MAX : BURST_LEN;
  assign start_acc_s = (state_r == S_IDLE) && START;
  // Strobes react to FULL/EMPTY in the same cycle so a stalled beat is never issued
  assign wr_en_s     = (state_r == S_WR_BEAT) && !FULL;
  assign rd_en_s     = (state_r == S_RD_BEAT) && !EMPTY;
  assign wr_last_s   = (wr_cnt_r + LEN_W'(1)) == len_r;
  assign rd_last_s   = (rd_cnt_r + LEN_W'(1)) == len_r;

  // Next-state decode for the burst sequencer
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (START) begin
          if ((MODE == MODE_NOP) || (len_clamp_s == {LEN_W{1'b0}})) begin
            state_nxt_s = S_DONE;
          end else if (MODE == MODE_RD) begin
            state_nxt_s = S_RD_BEAT;
          end else begin
            state_nxt_s = S_WR_BEAT;
          end
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_WR_BEAT: begin
        if (!wr_en_s) begin
          state_nxt_s = S_WR_BEAT;
        end else if (wr_last_s) begin
          state_nxt_s = (mode_r == MODE_WR_RD) ? S_RD_BEAT : S_FLUSH;
        end else if (GAP == 0) begin
          state_nxt_s = S_WR_BEAT;
        end else begin
          state_nxt_s = S_WR_GAP;
        end
      end
      S_WR_GAP: begin
        if (gap_cnt_r == GAP_LAST) begin
          state_nxt_s = S_WR_BEAT;
        end else begin
          state_nxt_s = S_WR_GAP;
        end
      end
      S_RD_BEAT: begin
        if (!rd_en_s) begin
          state_nxt_s = S_RD_BEAT;
        end else if (rd_last_s) begin
          state_nxt_s = S_FLUSH;
        end else if (GAP == 0) begin
          state_nxt_s = S_RD_BEAT;
        end else begin
          state_nxt_s = S_RD_GAP;
        end
      end
      S_RD_GAP: begin
        if (gap_cnt_r == GAP_LAST) begin
          state_nxt_s = S_RD_BEAT;
        end else begin
          state_nxt_s = S_RD_GAP;
        end
      end
      S_FLUSH: state_nxt_s = S_DONE;
      S_DONE:  state_nxt_s = S_IDLE;
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // State register, latched burst parameters, beat and gap counters
  always_ff @(posedge SYSCLK) begin
    if (RST) begin
      state_r   <= S_IDLE;
      mode_r    <= 2'b00;
      len_r     <= {LEN_W{1'b0}};
      seed_r    <= {DATA_W{1'b0}};
      wr_cnt_r  <= {LEN_W{1'b0}};
      rd_cnt_r  <= {LEN_W{1'b0}};
      gap_cnt_r <= {GAP_W{1'b0}};
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= (state_nxt_s != S_IDLE) && (state_nxt_s != S_DONE);
      done_r  <= (state_nxt_s == S_DONE);
      if (start_acc_s) begin
        mode_r   <= MODE;
        len_r    <= len_clamp_s;
        seed_r   <= SEED;
        wr_cnt_r <= {LEN_W{1'b0}};
        rd_cnt_r <= {LEN_W{1'b0}};
      end else begin
        if (wr_en_s) begin
          wr_cnt_r <= wr_cnt_r + LEN_W'(1);
        end
        if (rd_en_s) begin
          rd_cnt_r <= rd_cnt_r + LEN_W'(1);
        end
      end
      if ((state_r == state_nxt_s) && ((state_r == S_WR_GAP) || (state_r == S_RD_GAP))) begin
        gap_cnt_r <= gap_cnt_r + GAP_W'(1);
      end else begin
        gap_cnt_r <= {GAP_W{1'b0}};
      end
    end
  end

  assign WR_EN   = wr_en_s;
  assign RD_EN   = rd_en_s;
  assign FIFO_IN = wr_en_s ? (seed_r + DATA_W'(wr_cnt_r)) : {DATA_W{1'b0}};
  assign BUSY    = busy_r;
  assign DONE    = done_r;
  assign WR_CNT  = wr_cnt_r;
  assign RD_CNT  = rd_cnt_r;

`ifdef FIFO_TG_CHECK_EN
  logic              chk_vld_r;
  logic [DATA_W-1:0] chk_exp_r;
  logic [7:0]        err_cnt_r;

  // Compare returned read data one cycle after each read beat; error count saturates
  always_ff @(posedge SYSCLK) begin
    if (RST) begin
      chk_vld_r <= 1'b0;
      chk_exp_r <= {DATA_W{1'b0}};
      err_cnt_r <= 8'd0;
    end else begin
      chk_vld_r <= rd_en_s;
      chk_exp_r <= seed_r + DATA_W'(rd_cnt_r);
      if (start_acc_s) begin
        err_cnt_r <= 8'd0;
      end else if (chk_vld_r && (FIFO_OUT != chk_exp_r) && (err_cnt_r != 8'hFF)) begin
        err_cnt_r <= err_cnt_r + 8'd1;
      end else begin
        err_cnt_r <= err_cnt_r;
      end
    end
  end

  assign ERR_CNT = err_cnt_r;
`else
  logic unused_fifo_out_s;
  assign unused_fifo_out_s = ^FIFO_OUT;
  assign ERR_CNT = 8'd0;
`endif

endmodule
